// File: rtl/calc1_pkg.sv
// calc1_pkg
//   Shared definitions for the calc1 request driver: calc1 command codes,
//   calc1 response codes, the driver FSM state enum and a small helper to
//   recognise a live response on the calc1 response bus.
package calc1_pkg;

  // calc1 command codes (0 is the idle / no-operation bus value)
  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  // calc1 response codes
  localparam logic [1:0] RESP_NONE     = 2'd0;
  localparam logic [1:0] RESP_OK       = 2'd1;
  localparam logic [1:0] RESP_ERR      = 2'd2;
  localparam logic [1:0] RESP_INTERNAL = 2'd3;

  // Driver FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND1 = 3'd1,
    ST_SEND2 = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Any nonzero response code means calc1 is reporting something
  function automatic logic resp_seen(input logic [1:0] resp);
    return resp != RESP_NONE;
  endfunction

endpackage

// File: rtl/calc1_req_driver_if.sv
// calc1_req_driver_if
//   Bundles everything the request driver exchanges with the outside world:
//     op_*      : operation offer from the requester (valid/ready handshake)
//     req_*     : request bus towards one calc1 port
//     calc_*    : response bus coming back from that calc1 port
//     res_*     : captured result towards the requester (valid/ready)
//     stray_resp: sticky flag for responses seen while not waiting
//   Modports:
//     slave  : the driver itself
//     master : the requester / calc1 side (a testbench plays both)
interface calc1_req_driver_if;
  import calc1_pkg::*;

  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_cmd;
  logic [31:0] op_data1;
  logic [31:0] op_data2;

  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;

  logic [1:0]  calc_resp_in;
  logic [31:0] calc_data_in;

  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_resp;
  logic [31:0] res_data;
  logic        res_timeout;

  logic        stray_resp;

  modport slave (
    input  op_valid, op_cmd, op_data1, op_data2,
    input  calc_resp_in, calc_data_in,
    input  res_ready,
    output op_ready, req_cmd_out, req_data_out,
    output res_valid, res_resp, res_data, res_timeout,
    output stray_resp
  );

  modport master (
    output op_valid, op_cmd, op_data1, op_data2,
    output calc_resp_in, calc_data_in,
    output res_ready,
    input  op_ready, req_cmd_out, req_data_out,
    input  res_valid, res_resp, res_data, res_timeout,
    input  stray_resp
  );

endinterface

// File: rtl/calc1_req_driver.sv
// calc1_req_driver
//   Drives one calc1 port with a two-cycle request (cmd+data1, then data2),
//   waits for the response with a timeout, and presents the captured result
//   on a valid/ready handshake. Command 0 short-circuits straight to a zero
//   result without touching the calc1 bus.
//   Ports:
//     c_clk  : sole clock, rising edge
//     reset  : asynchronous, active-high reset
//     bus    : calc1_req_driver_if.slave (operation, calc1 bus, result, stray flag)
//   Parameter:
//     TIMEOUT_CYCLES : WAIT cycles allowed before declaring a timeout (2..255)
module calc1_req_driver
  import calc1_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               c_clk,
  input  logic               reset,
  calc1_req_driver_if.slave  bus
);

  // Last WAIT count value before the timeout fires
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [31:0] data1_q, data1_d;
  logic [31:0] data2_q, data2_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  res_resp_q, res_resp_d;
  logic [31:0] res_data_q, res_data_d;
  logic        res_timeout_q, res_timeout_d;
  logic        stray_q, stray_d;

  // State and datapath registers; reset drops any in-flight operation and
  // clears the captured result and the stray flag.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cmd_q         <= CMD_NOP;
      data1_q       <= '0;
      data2_q       <= '0;
      cnt_q         <= '0;
      res_resp_q    <= RESP_NONE;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
      stray_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      data1_q       <= data1_d;
      data2_q       <= data2_d;
      cnt_q         <= cnt_d;
      res_resp_q    <= res_resp_d;
      res_data_q    <= res_data_d;
      res_timeout_q <= res_timeout_d;
      stray_q       <= stray_d;
    end
  end

  // Next-state logic and request-bus outputs
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    data1_d       = data1_q;
    data2_d       = data2_q;
    cnt_d         = cnt_q;
    res_resp_d    = res_resp_q;
    res_data_d    = res_data_q;
    res_timeout_d = res_timeout_q;
    // A response is only expected in WAIT; anything else is remembered
    stray_d       = stray_q | ((state_q != ST_WAIT) && resp_seen(bus.calc_resp_in));

    bus.op_ready     = 1'b0;
    bus.req_cmd_out  = CMD_NOP;
    bus.req_data_out = '0;

    case (state_q)
      ST_IDLE: begin
        // Held low while reset is asserted even though the state is IDLE
        bus.op_ready = ~reset;
        if (bus.op_valid) begin
          if (bus.op_cmd != CMD_NOP) begin
            cmd_d   = bus.op_cmd;
            data1_d = bus.op_data1;
            data2_d = bus.op_data2;
            state_d = ST_SEND1;
          end else begin
            res_resp_d    = RESP_NONE;
            res_data_d    = '0;
            res_timeout_d = 1'b0;
            state_d       = ST_DONE;
          end
        end
      end

      ST_SEND1: begin
        bus.req_cmd_out  = cmd_q;
        bus.req_data_out = data1_q;
        state_d          = ST_SEND2;
      end

      ST_SEND2: begin
        bus.req_data_out = data2_q;
        cnt_d            = '0;
        state_d          = ST_WAIT;
      end

      ST_WAIT: begin
        // A response on the final WAIT cycle still wins over the timeout
        if (resp_seen(bus.calc_resp_in)) begin
          res_resp_d    = bus.calc_resp_in;
          res_data_d    = bus.calc_data_in;
          res_timeout_d = 1'b0;
          state_d       = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          res_resp_d    = RESP_NONE;
          res_data_d    = '0;
          res_timeout_d = 1'b1;
          state_d       = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_DONE: begin
        // No op is accepted on this edge; IDLE offers op_ready next cycle
        if (bus.res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.res_valid   = (state_q == ST_DONE);
  assign bus.res_resp    = res_resp_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_timeout = res_timeout_q;
  assign bus.stray_resp  = stray_q;

endmodule

// File: doc/calc1_req_driver.md
CALC1_REQ_DRIVER -- requirements
Module: calc1_req_driver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max WAIT cycles before declaring timeout (legal 2..255).
REQ-002 SHALL have port c_clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port op_valid  input  1  operation offered.
REQ-005 SHALL have port op_ready  output  1  operation accepted when high with op_valid at rising edge.
REQ-006 SHALL have port op_cmd  input  4  calc1 command code.
REQ-007 SHALL have port op_data1  input  32  first operand.
REQ-008 SHALL have port op_data2  input  32  second operand.
REQ-009 SHALL have port req_cmd_out  output  4  drives calc1 reqN_cmd_in.
REQ-010 SHALL have port req_data_out  output  32  drives calc1 reqN_data_in.
REQ-011 SHALL have port calc_resp_in  input  2  calc1 out_respN.
REQ-012 SHALL have port calc_data_in  input  32  calc1 out_dataN.
REQ-013 SHALL have port res_valid  output  1  result available.
REQ-014 SHALL have port res_ready  input  1  result consumed when high with res_valid at rising edge.
REQ-015 SHALL have port res_resp  output  2  captured response code.
REQ-016 SHALL have port res_data  output  32  captured result data.
REQ-017 SHALL have port res_timeout  output  1  result is a timeout, not a calc1 response.
REQ-018 SHALL have port stray_resp  output  1  sticky: nonzero calc_resp_in seen outside WAIT.

Function
REQ-019 SHALL implement FSM states IDLE, SEND1, SEND2, WAIT, DONE; op_ready=1 only in IDLE.
REQ-020 SHALL, on op accept in IDLE with op_cmd!=0, register cmd/data1/data2 and enter SEND1 next cycle.
REQ-021 SHALL, on op accept with op_cmd==0, enter DONE directly with res_resp=0, res_data=0, res_timeout=0, no bus activity.
REQ-022 SHALL drive req_cmd_out=cmd, req_data_out=data1 for exactly the SEND1 cycle.
REQ-023 SHALL drive req_cmd_out=0, req_data_out=data2 for exactly the SEND2 cycle, then WAIT.
REQ-024 SHALL drive req_cmd_out=0, req_data_out=0 in IDLE, WAIT, DONE.
REQ-025 SHALL forward any nonzero cmd (including invalid codes 3,4,7..15) unmodified; error reporting is calc1's job.
REQ-026 SHALL in WAIT sample calc_resp_in each edge; first nonzero value captures resp and calc_data_in into res_resp/res_data, res_timeout=0, enters DONE.
REQ-027 SHALL count WAIT cycles from 0; if calc_resp_in==0 at edge with count==TIMEOUT_CYCLES-1, enter DONE with res_resp=0, res_data=0, res_timeout=1.
REQ-028 SHALL hold res_valid=1 and res_resp/res_data/res_timeout stable in DONE until res_ready; then IDLE.
REQ-029 SHALL not accept a new op in the DONE->IDLE handshake cycle; earliest next accept is the following edge.
REQ-030 SHALL set stray_resp when calc_resp_in!=0 at an edge in IDLE, SEND1, SEND2 or DONE; cleared only by reset.
REQ-031 SHALL hold res_resp/res_data/res_timeout at last captured value outside DONE; res_valid=0 outside DONE.

Reset
REQ-032 SHALL on reset assertion immediately force state IDLE, all outputs 0 except op_ready (0 while reset high, 1 after release), counter 0, stray_resp 0.
REQ-033 SHALL drop any in-flight op on reset; a calc1 response arriving after release SHALL set stray_resp only.

Structure
REQ-034 SHALL take command codes (ADD=1, SUB=2, SHL=5, SHR=6), response codes (NONE=0, OK=1, ERR=2, INTERNAL=3) and the FSM state enum from shared package calc1_pkg.
REQ-035 SHALL be a single module; no sub-module; one instance per calc1 port.

Verification
REQ-036 SHALL cover: cmd=1, data1=0x00000001, data2=0x01FFFFFF, model replies resp=1 data=0x02000000 after 3 WAIT cycles -> bus (1,0x1),(0,0x01FFFFFF); res_resp=1, res_data=0x02000000.
REQ-037 SHALL cover: cmd=1, 0xFFFFFFFF+0x1, model replies resp=2 data=0 -> res_resp=2, res_data=0, res_timeout=0.
REQ-038 SHALL cover: cmd=5, no model reply, TIMEOUT_CYCLES=16 -> res_valid exactly 16 cycles after SEND2, res_timeout=1, res_resp=0.
REQ-039 SHALL cover: res_ready low 5 cycles in DONE with op_valid high -> outputs stable, op_ready=0; second op accepted one cycle after result handshake.
REQ-040 SHALL cover: reset pulsed in WAIT, model replies resp=1 two cycles after release -> outputs 0 during reset, no res_valid, stray_resp=1.
REQ-041 SHALL cover: op_cmd=0 -> req_cmd_out stays 0, res_valid one cycle after accept, res_resp=0.
